// File: rtl/fsqrt_seq.sv
// fsqrt_seq -- sequencer for an IEEE-754 single-precision square root.
//
// Accepts one request at a time and drives its operand to an external
// fixed-latency square-root datapath. Special operands are resolved locally
// and skip the datapath. The result is held until writeback takes it.
//
// Parameters
//   LAT          cycles from a change on sq_rs1 until sq_res is valid (>= 1)
// Ports
//   clk          rising-edge clock
//   resetn       synchronous active-low reset
//   issue_valid  request presented
//   issue_ready  request accepted when high together with issue_valid
//   issue_rd     destination register tag of the request
//   issue_rs1    single-precision operand of the request
//   flush        abort any in-flight operation, block accept in IDLE
//   sq_rs1       registered operand driven to the datapath
//   sq_res       datapath result
//   wb_valid     result available
//   wb_ready     writeback consumer accepts
//   wb_rd        tag of the result
//   wb_data      result value
//   wb_nv        invalid-operation flag
//   busy         high whenever the sequencer is not idle
module fsqrt_seq #(
  parameter int LAT = 14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_rs1,
  input  logic        flush,
  output logic [31:0] sq_rs1,
  input  logic [31:0] sq_res,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_nv,
  output logic        busy
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT > 0) ? (LAT - 1) : 0);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [31:0]       sq_rs1_r;
  logic [31:0]       wb_data_r;
  logic [4:0]        wb_rd_r;
  logic              wb_nv_r;
  logic [33:0]       class_s;
  logic              accept_s;

  // Operand classification: {special, nv, result}. Only positive normal
  // operands leave special clear and need the datapath.
  function automatic logic [33:0] classify(input logic [31:0] op);
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] mant;
    logic [33:0] res;
    sign = op[31];
    expo = op[30:23];
    mant = op[22:0];
    if (expo == 8'h00) begin
      // zero passes through unchanged, a denormal flushes to signed zero
      if (mant == 23'd0) begin
        res = {1'b1, 1'b0, op};
      end else begin
        res = {1'b1, 1'b0, sign, 31'd0};
      end
    end else if (expo == 8'hFF) begin
      if (mant != 23'd0) begin
        // quiet bit clear means signalling NaN, which raises nv
        res = {1'b1, ~mant[22], QNAN};
      end else if (sign) begin
        res = {1'b1, 1'b1, QNAN};
      end else begin
        res = {1'b1, 1'b0, PINF};
      end
    end else if (sign) begin
      res = {1'b1, 1'b1, QNAN};
    end else begin
      res = {1'b0, 1'b0, 32'd0};
    end
    return res;
  endfunction

  // Classify the presented operand and qualify the accept handshake.
  always_comb begin
    class_s  = classify(issue_rs1);
    accept_s = (state_r == IDLE) && issue_valid && !flush;
  end

  // Sequencer FSM with all result registers; flush outranks cnt==0 and wb_ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      sq_rs1_r  <= 32'd0;
      wb_data_r <= 32'd0;
      wb_rd_r   <= 5'd0;
      wb_nv_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wb_rd_r  <= issue_rd;
            sq_rs1_r <= issue_rs1;
            if (class_s[33]) begin
              state_r   <= HOLD;
              wb_data_r <= class_s[31:0];
              wb_nv_r   <= class_s[32];
              cnt_r     <= '0;
            end else begin
              state_r <= RUN;
              cnt_r   <= CNT_LOAD;
            end
          end
        end
        RUN: begin
          // sq_rs1 is not touched here: the datapath re-reads it late
          if (flush) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == '0) begin
            wb_data_r <= sq_res;
            wb_nv_r   <= 1'b0;
            state_r   <= HOLD;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        HOLD: begin
          if (flush || wb_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign issue_ready = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign wb_valid    = (state_r == HOLD);
  assign sq_rs1      = sq_rs1_r;
  assign wb_data     = wb_data_r;
  assign wb_rd       = wb_rd_r;
  assign wb_nv       = wb_nv_r;

endmodule

// File: tb/tb_fsqrt_seq.sv
// Self-checking bench for fsqrt_seq: a transaction-level reference model and
// a behavioural fixed-latency datapath, compared on every cycle, plus
// directed cases with hand-computed expectations.
module tb_fsqrt_seq;

  localparam int LAT = 14;

  logic        clk = 1'b0;
  logic        resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic [31:0] issue_rs1;
  logic        flush;
  logic [31:0] sq_rs1;
  logic [31:0] sq_res;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_nv;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 waiting on datapath, 2 result offered
  int          m_ph = 0;
  int          m_left = 0;
  logic [31:0] m_sq = 32'd0;
  logic [31:0] m_data = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_nv = 1'b0;
  bit          m_clean = 1'b1;

  // datapath model state
  logic [31:0] dp_last = 32'd0;
  int          dp_age = 0;

  fsqrt_seq #(.LAT(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .flush(flush),
    .sq_rs1(sq_rs1), .sq_res(sq_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_nv(wb_nv), .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in square root: exact for the directed operands, a hash otherwise
  function automatic logic [31:0] dp_func(input logic [31:0] x);
    if (x == 32'h4080_0000) return 32'h4000_0000;
    if (x == 32'h4110_0000) return 32'h4040_0000;
    return (x >> 1) ^ 32'h1357_9BDF;
  endfunction

  // {special, nv, value} from the IEEE category of the operand
  function automatic logic [33:0] ref_special(input logic [31:0] x);
    bit          s;
    logic [7:0]  e;
    logic [22:0] m;
    s = x[31]; e = x[30:23]; m = x[22:0];
    if (e == 8'hFF && m != 23'd0) return {1'b1, !m[22], 32'h7FC0_0000};
    if (e == 8'h00 && m == 23'd0) return {1'b1, 1'b0, x};
    if (e == 8'h00) return {1'b1, 1'b0, s, 31'd0};
    if (s) return {1'b1, 1'b1, 32'h7FC0_0000};
    if (e == 8'hFF) return {1'b1, 1'b0, 32'h7F80_0000};
    return {1'b0, 1'b0, 32'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock: advance model on the edge, update datapath, compare on negedge
  task automatic step();
    logic [33:0] r;
    @(posedge clk);
    if (!resetn) begin
      m_ph = 0; m_left = 0; m_sq = 32'd0; m_data = 32'd0;
      m_rd = 5'd0; m_nv = 1'b0; m_clean = 1'b1;
    end else begin
      case (m_ph)
        0: if (issue_valid && !flush) begin
          m_clean = 1'b0;
          m_rd = issue_rd;
          m_sq = issue_rs1;
          r = ref_special(issue_rs1);
          if (r[33]) begin
            m_ph = 2; m_nv = r[32]; m_data = r[31:0];
          end else begin
            m_ph = 1; m_left = LAT;
          end
        end
        1: if (flush) m_ph = 0;
           else begin
             m_left--;
             if (m_left == 0) begin
               m_ph = 2; m_data = dp_func(m_sq); m_nv = 1'b0;
             end
           end
        2: if (flush || wb_ready) m_ph = 0;
        default: m_ph = 0;
      endcase
    end
    #1;
    if (sq_rs1 !== dp_last) begin
      dp_last = sq_rs1;
      dp_age = 0;
    end else if (dp_age < 100000) begin
      dp_age++;
    end
    sq_res = (dp_age >= LAT - 1) ? dp_func(dp_last) : (32'hDEAD_BEEF ^ dp_age);
    @(negedge clk);
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, m_ph == 0});
    chk("busy", {31'd0, busy}, {31'd0, m_ph != 0});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_ph == 2});
    if (m_ph == 2 || m_clean) begin
      chk("wb_data", wb_data, m_data);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
      chk("wb_nv", {31'd0, wb_nv}, {31'd0, m_nv});
    end
    if (m_ph == 1 || m_clean) chk("sq_rs1", sq_rs1, m_sq);
  endtask

  // issue one request from idle and wait (bounded) for the result
  task automatic do_op(input logic [31:0] rs1, input logic [4:0] rd, output int n);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rd = rd;
    step();
    issue_valid = 1'b0;
    n = 1;
    while (!wb_valid && n < LAT + 10) begin
      step();
      n++;
    end
    if (!wb_valid) begin
      checks++; errors++;
      $display("FAIL wb_timeout: got no wb_valid expected one within %0d cycles", LAT + 10);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x = 32'h4080_0000;
      1: x[30:0] = 31'd0;                                   // +/-0
      2: begin x[30:23] = 8'h00; x[0] = 1'b1; end          // denormal
      3: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end      // +/-inf
      4: begin x[30:23] = 8'hFF; x[22] = 1'b1; end         // quiet NaN
      5: begin x[30:23] = 8'hFF; x[22] = 1'b0; x[0] = 1'b1; end // sNaN
      6: begin x[31] = 1'b1; x[30:23] = 8'($urandom_range(1, 254)); end
      default: begin x[31] = 1'b0; x[30:23] = 8'($urandom_range(1, 254)); end
    endcase
    return x;
  endfunction

  logic [31:0] sp_op   [6] = '{32'hC080_0000, 32'h7F80_0001, 32'h8000_0000,
                               32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0001};
  logic [31:0] sp_data [6] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000,
                               32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000};
  logic        sp_nv   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int n;
    resetn = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3; issue_rs1 = 32'h0000_0000;
    flush = 1'b0; wb_ready = 1'b1; sq_res = 32'd0;

    // reset with a request held: must not be accepted
    repeat (3) step();
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_sq_rs1", sq_rs1, 32'd0);
    issue_valid = 1'b0;
    resetn = 1'b1;
    step();

    // normal operand: 4.0 -> 2.0 at cycle LAT+1
    do_op(32'h4080_0000, 5'd5, n);
    chk("lat_4_0", n, LAT + 1);
    chk("data_4_0", wb_data, 32'h4000_0000);
    chk("rd_4_0", {27'd0, wb_rd}, 32'd5);
    chk("nv_4_0", {31'd0, wb_nv}, 32'd0);
    step();

    // special operands resolve one cycle after accept
    for (int i = 0; i < 6; i++) begin
      do_op(sp_op[i], 5'(i + 10), n);
      chk("sp_lat", n, 32'd1);
      chk("sp_data", wb_data, sp_data[i]);
      chk("sp_nv", {31'd0, wb_nv}, {31'd0, sp_nv[i]});
      step();
    end

    // backpressure: result held stable for 5 cycles, new request ignored
    wb_ready = 1'b0;
    do_op(32'h4110_0000, 5'd9, n);
    issue_valid = 1'b1; issue_rs1 = 32'h0000_0000; issue_rd = 5'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("hold_data", wb_data, 32'h4040_0000);
      chk("hold_rd", {27'd0, wb_rd}, 32'd9);
      chk("hold_ready", {31'd0, issue_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    step();   // leave HOLD; request still presented but not taken this cycle
    chk("release_busy", {31'd0, busy}, 32'd0);
    issue_valid = 1'b0;
    step();

    // flush with cnt == 3
    issue_valid = 1'b1; issue_rs1 = 32'h4080_0000; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    repeat (LAT - 4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush3_busy", {31'd0, busy}, 32'd0);
    chk("flush3_valid", {31'd0, wb_valid}, 32'd0);
    repeat (3) step();

    // flush coincident with cnt == 0
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    repeat (LAT - 1) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush0_valid", {31'd0, wb_valid}, 32'd0);
    repeat (3) step();

    // reset mid-RUN with a request held
    issue_valid = 1'b1;
    step();
    issue_rs1 = 32'hC080_0000;
    repeat (4) step();
    resetn = 1'b0;
    step();
    chk("midrst_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_data", wb_data, 32'd0);
    chk("midrst_sq", sq_rs1, 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_accept", {31'd0, busy}, 32'd1);
    issue_valid = 1'b0;
    repeat (3) step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rs1   = rand_operand();
      issue_rd    = 5'($urandom_range(0, 31));
      flush       = ($urandom_range(0, 39) == 0);
      wb_ready    = ($urandom_range(0, 9) < 7);
      resetn      = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsqrt_seq.md
FSQRT_SEQ -- requirements
Module: fsqrt_seq

Interface
REQ-001 SHALL have parameter LAT, default 14, meaning the fixed cycle count from sq_rs1 change to sq_res valid on the downstream square-root datapath.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port issue_valid, input, 1, a sqrt request is presented.
REQ-005 SHALL have port issue_ready, output, 1, request accepted when high together with issue_valid.
REQ-006 SHALL have port issue_rd, input, 5, destination register tag.
REQ-007 SHALL have port issue_rs1, input, 32, IEEE-754 single operand.
REQ-008 SHALL have port flush, input, 1, abort any in-flight operation.
REQ-009 SHALL have port sq_rs1, output, 32, registered operand driven to the square-root datapath.
REQ-010 SHALL have port sq_res, input, 32, square-root datapath result.
REQ-011 SHALL have port wb_valid, output, 1, result available.
REQ-012 SHALL have port wb_ready, input, 1, writeback consumer accepts.
REQ-013 SHALL have port wb_rd, output, 5, tag of the result.
REQ-014 SHALL have port wb_data, output, 32, result value.
REQ-015 SHALL have port wb_nv, output, 1, invalid-operation flag.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HOLD; issue_ready = (state==IDLE).
REQ-018 Accept (IDLE & issue_valid) SHALL latch issue_rd into wb_rd, load sq_rs1 <= issue_rs1, and classify the operand in the same cycle.
REQ-019 sq_rs1 SHALL remain stable from accept until the FSM leaves RUN, because the datapath reads the operand in both its first and last stages.
REQ-020 Normal operands (positive, normal exponent 1..254) SHALL go to RUN with counter cnt <= LAT-1.
REQ-021 RUN SHALL decrement cnt each cycle; when cnt==0, it SHALL capture wb_data <= sq_res, set wb_nv <= 0, and go to HOLD, giving LAT+1 cycles from accept to wb_valid.
REQ-022 Special operands SHALL bypass RUN and go to HOLD on the cycle after accept:
  - +/-0 -> wb_data = operand, nv=0
  - denormal (exp=0, mant!=0) -> signed zero {sign,31'b0}, nv=0
  - +inf -> 0x7F800000, nv=0
  - quiet NaN -> 0x7FC00000, nv=0
  - signalling NaN -> 0x7FC00000, nv=1
  - negative nonzero non-NaN, including -inf -> 0x7FC00000, nv=1
REQ-023 wb_valid SHALL equal (state==HOLD); wb_data, wb_rd and wb_nv SHALL be stable while wb_valid & !wb_ready.
REQ-024 HOLD & wb_ready SHALL return to IDLE next cycle; no new accept is allowed in that same cycle.
REQ-025 flush in RUN or HOLD SHALL force IDLE next cycle with no writeback; flush in IDLE SHALL block accept that cycle.
REQ-026 flush SHALL take priority over the cnt==0 transition and over wb_ready.
REQ-027 cnt SHALL be ceil(log2(LAT+1)) bits wide and SHALL never wrap below 0.

Reset
REQ-028 resetn=0 SHALL force state=IDLE, cnt=0, sq_rs1=0, wb_data=0, wb_rd=0, wb_nv=0, wb_valid=0, and busy=0.
REQ-029 After reset the outputs SHALL read issue_ready=1.
REQ-030 Reset mid-RUN or mid-HOLD SHALL discard the operation with no writeback.
REQ-031 Reset SHALL take priority over flush and all other inputs.

Verification
REQ-032 SHALL cover: accept rs1=0x40800000 (4.0), rd=5, with the model returning 0x40000000 -> wb_valid at cycle LAT+1, wb_data=0x40000000, wb_rd=5, nv=0.
REQ-033 SHALL cover: rs1=0xC0800000 (-4.0) -> wb_valid 1 cycle after accept, data=0x7FC00000, nv=1; rs1=0x7F800001 -> 0x7FC00000, nv=1.
REQ-034 SHALL cover: rs1=0x80000000 -> data=0x80000000; rs1=0x00000001 -> data=0x00000000; rs1=0x7F800000 -> 0x7F800000; all with nv=0.
REQ-035 SHALL cover: wb_ready held low 5 cycles in HOLD -> outputs stable and issue_ready=0; wb_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover: flush at RUN cnt=3 -> IDLE next cycle, no wb_valid; flush coincident with cnt==0 -> no writeback.
REQ-037 SHALL cover: resetn=0 mid-RUN -> all outputs at reset values next cycle; issue_valid held high during reset -> no accept until resetn=1.
